// File: rtl/mem_pkg.sv
// Shared memory-access definitions for byte_ram and the load/store unit.
//   - access size encodings and a helper returning the byte count of a size
//   - request/response field layouts (sized for the widest 64-bit build)
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 64;

    typedef struct packed {
        logic                  write;
        logic [1:0]            size;
        logic                  sgn;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  error;
        logic [MEM_DATA_W-1:0] rdata;
    } mem_resp_t;

    function automatic int unsigned size_bytes(logic [1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering between a memory window and right-justified data.
//   size   : access size encoding (mem_pkg SIZE_*)
//   sgn    : sign-extend sub-word loads
//   rwin   : memory window, byte j = mem[addr + j]
//   wdata  : right-justified store data
//   rdata  : right-justified, extended load data
//   wwin   : store bytes laid out like rwin
//   wmask  : which window bytes a store writes
module byte_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]              size,
    input  logic                    sgn,
    input  logic [DATA_WIDTH-1:0]   rwin,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [DATA_WIDTH-1:0]   wwin,
    output logic [DATA_WIDTH/8-1:0] wmask
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    int unsigned n;
    int unsigned src;

    always_comb begin
        rdata = '0;
        wwin  = '0;
        wmask = '0;
        src   = 0;
        // Oversized requests are flagged as errors upstream; clamp to keep indices legal.
        n = size_bytes(size);
        if (n > NB) begin
            n = NB;
        end
        for (int j = 0; j < NB; j++) begin
            if (j < n) begin
                // The byte-order mapping is its own inverse, so loads and stores share it.
                src = BIG_ENDIAN ? (n - 1 - j) : j;
                rdata[8*j +: 8] = rwin[8*src +: 8];
                wwin[8*j +: 8]  = wdata[8*src +: 8];
                wmask[j]        = 1'b1;
            end else if (sgn) begin
                rdata[8*j +: 8] = {8{rdata[8*n-1]}};
            end
        end
    end

endmodule

// File: rtl/byte_ram.sv
// Byte-addressed data memory with byte/half/word(/dword) access and one-deep response register.
//   clk, rst                  : clock, synchronous active-high reset (response state only)
//   req_valid/req_ready       : request handshake
//   req_write/size/signed     : store select, access size, sign-extend loads
//   req_addr/req_wdata        : byte address, right-justified store data
//   resp_valid/resp_ready     : response handshake
//   resp_rdata/resp_error     : load data (0 for stores/errors), access error flag
module byte_ram
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned IDXW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    logic                  accept;
    logic                  err;
    logic [ADDR_WIDTH:0]   n_w;
    logic [ADDR_WIDTH:0]   byte_addr [NB];
    logic [IDXW-1:0]       byte_idx  [NB];
    logic [DATA_WIDTH-1:0] rwin;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] wwin;
    logic [NB-1:0]         wmask;

    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_error_q;

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;

    // Range check runs one bit wider than the address so addr + N cannot wrap.
    always_comb begin
        n_w = (ADDR_WIDTH+1)'(size_bytes(req_size));
        err = ((req_addr & (n_w[ADDR_WIDTH-1:0] - 1'b1)) != '0)
            || (({1'b0, req_addr} + n_w) > DEPTH_W)
            || (size_bytes(req_size) > NB);
    end

    // Window of NB bytes from req_addr; bytes past the end read as zero.
    always_comb begin
        rwin = '0;
        for (int i = 0; i < NB; i++) begin
            byte_addr[i] = {1'b0, req_addr} + (ADDR_WIDTH+1)'(i);
            byte_idx[i]  = byte_addr[i][IDXW-1:0];
            if (byte_addr[i] < DEPTH_W) begin
                rwin[8*i +: 8] = mem[byte_idx[i]];
            end
        end
    end

    byte_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .size  (req_size),
        .sgn   (req_signed),
        .rwin  (rwin),
        .wdata (req_wdata),
        .rdata (ld_data),
        .wwin  (wwin),
        .wmask (wmask)
    );

    always_ff @(posedge clk) begin
        if (!rst && accept && req_write && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    mem[byte_idx[i]] <= wwin[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (!req_write && !err) ? ld_data : '0;
            resp_error_q <= err;
        end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_byte_ram.sv
module tb_byte_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        sel_le;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        be_req_ready, be_resp_valid, be_resp_error;
    logic [31:0] be_resp_rdata;
    logic        le_req_ready, le_resp_valid, le_resp_error;
    logic [31:0] le_resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_ram #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_BYTES (4096),
        .BIG_ENDIAN  (1'b1),
        .INIT_FILE   ("")
    ) u_be (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && !sel_le),
        .req_ready  (be_req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (be_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (be_resp_rdata),
        .resp_error (be_resp_error)
    );

    byte_ram #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_BYTES (4096),
        .BIG_ENDIAN  (1'b0),
        .INIT_FILE   ("")
    ) u_le (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && sel_le),
        .req_ready  (le_req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (le_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (le_resp_rdata),
        .resp_error (le_resp_error)
    );

    typedef struct {
        string       name;
        bit          le;
        bit          wr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, got, exp);
        end
    endtask

    task automatic add(input string name, input bit le, input bit wr, input logic [1:0] size,
                       input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_err);
        vec_t v;
        v.name = name; v.le = le; v.wr = wr; v.size = size; v.sgn = sgn;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge so the request is stable at the next rising edge.
    task automatic drive(input bit le, input bit wr, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        sel_le     = le;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; sel_le = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

        // Reset: valid requests during reset must produce no response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_valid", {31'd0, be_resp_valid}, 32'd0);
        check("reset_resp_rdata", be_resp_rdata, 32'd0);
        check("reset_resp_error", {31'd0, be_resp_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, be_req_ready}, 32'd1);

        // Big endian
        add("be_st_w",       0, 1, 2, 0, 32'h10,  32'h11223344, 32'h0,        0);
        add("be_ld_b_11",    0, 0, 0, 0, 32'h11,  32'h0,        32'h00000022, 0);
        add("be_ld_sh_12",   0, 0, 1, 1, 32'h12,  32'h0,        32'h00003344, 0);
        add("be_ld_h_10",    0, 0, 1, 0, 32'h10,  32'h0,        32'h00001122, 0);
        add("be_ld_w_10",    0, 0, 2, 1, 32'h10,  32'h0,        32'h11223344, 0);
        add("be_st_b_80",    0, 1, 0, 0, 32'h20,  32'hFFFFFF80, 32'h0,        0);
        add("be_ld_sb_20",   0, 0, 0, 1, 32'h20,  32'h0,        32'hFFFFFF80, 0);
        add("be_ld_ub_20",   0, 0, 0, 0, 32'h20,  32'h0,        32'h00000080, 0);
        add("be_st_h_30",    0, 1, 1, 0, 32'h30,  32'h00009ABC, 32'h0,        0);
        add("be_ld_sh_30",   0, 0, 1, 1, 32'h30,  32'h0,        32'hFFFF9ABC, 0);
        add("be_ld_b_31",    0, 0, 0, 0, 32'h31,  32'h0,        32'h000000BC, 0);
        add("be_ld_w_mis",   0, 0, 2, 0, 32'h3,   32'h0,        32'h0,        1);
        add("be_st_w_ffc",   0, 1, 2, 0, 32'hFFC, 32'h01020304, 32'h0,        0);
        add("be_st_w_ffe",   0, 1, 2, 0, 32'hFFE, 32'hDEADBEEF, 32'h0,        1);
        add("be_st_b_oor",   0, 1, 0, 0, 32'h1000,32'h000000EE, 32'h0,        1);
        add("be_ld_w_ffc",   0, 0, 2, 0, 32'hFFC, 32'h0,        32'h01020304, 0);
        add("be_ld_b_fff",   0, 0, 0, 0, 32'hFFF, 32'h0,        32'h00000004, 0);
        add("be_ld_size3",   0, 0, 3, 0, 32'h10,  32'h0,        32'h0,        1);
        add("be_st_size3",   0, 1, 3, 0, 32'h10,  32'hFFFFFFFF, 32'h0,        1);
        add("be_ld_w_10b",   0, 0, 2, 0, 32'h10,  32'h0,        32'h11223344, 0);
        // Little endian
        add("le_st_w",       1, 1, 2, 0, 32'h0,   32'hAABBCCDD, 32'h0,        0);
        add("le_ld_b_0",     1, 0, 0, 0, 32'h0,   32'h0,        32'h000000DD, 0);
        add("le_ld_h_2",     1, 0, 1, 0, 32'h2,   32'h0,        32'h0000AABB, 0);
        add("le_ld_sb_3",    1, 0, 0, 1, 32'h3,   32'h0,        32'hFFFFFFAA, 0);
        add("le_st_w_4",     1, 1, 2, 0, 32'h4,   32'h0,        32'h0,        0);
        add("le_st_h_4",     1, 1, 1, 0, 32'h4,   32'h00001234, 32'h0,        0);
        add("le_ld_w_4",     1, 0, 2, 0, 32'h4,   32'h0,        32'h00001234, 0);
        add("le_ld_h_mis",   1, 0, 1, 0, 32'h5,   32'h0,        32'h0,        1);

        foreach (vecs[i]) begin
            drive(vecs[i].le, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                  vecs[i].wdata);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid"},
                  {31'd0, vecs[i].le ? le_resp_valid : be_resp_valid}, 32'd1);
            check({vecs[i].name, "_rdata"},
                  vecs[i].le ? le_resp_rdata : be_resp_rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},
                  {31'd0, vecs[i].le ? le_resp_error : be_resp_error},
                  {31'd0, vecs[i].exp_err});
        end
        idle();
        #1;
        check("drain_valid", {31'd0, be_resp_valid}, 32'd0);

        // Backpressure: first response held, next request waits.
        resp_ready = 1'b0;
        drive(0, 0, 2, 0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        check("bp_first_valid", {31'd0, be_resp_valid}, 32'd1);
        drive(0, 0, 0, 0, 32'h11, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("bp_req_ready", {31'd0, be_req_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, be_resp_valid}, 32'd1);
            check("bp_hold_rdata", be_resp_rdata, 32'h11223344);
            check("bp_hold_err", {31'd0, be_resp_error}, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_valid", {31'd0, be_resp_valid}, 32'd1);
        check("bp_rel_rdata0", be_resp_rdata, 32'h00000022);
        drive(0, 0, 1, 0, 32'h12, 32'h0);
        @(posedge clk);
        #1;
        check("bp_rel_rdata1", be_resp_rdata, 32'h00003344);
        idle();

        // Store then load on consecutive cycles.
        drive(0, 1, 2, 0, 32'h50, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("sl_store_rdata", be_resp_rdata, 32'h0);
        drive(0, 0, 2, 0, 32'h50, 32'h0);
        @(posedge clk);
        #1;
        check("sl_load_rdata", be_resp_rdata, 32'hCAFEF00D);
        idle();

        // Stores during reset must not reach memory.
        drive(0, 1, 2, 0, 32'h40, 32'h01010101);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40;
        req_wdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst2_resp_valid", {31'd0, be_resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        drive(0, 0, 2, 0, 32'h40, 32'h0);
        @(posedge clk);
        #1;
        check("rst2_mem_kept", be_resp_rdata, 32'h01010101);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
